// File: rtl/noc_ram_pkg.sv
// Shared field layout for the noc_ram request/response words.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
//
// Request word  {data, addr, wr, rd, src}, MSB first.
// Response word {data, node, is_ack},       MSB first.
// Offsets are functions of the widths so that any parameterisation of the
// RAM shares one definition of the layout.
package noc_ram_pkg;

  localparam int DEF_WIDTH        = 32;
  localparam int DEF_ADDR_WIDTH   = 10;
  localparam int DEF_N            = 16;
  localparam int DEF_N_ADDR_WIDTH = $clog2(DEF_N);

  // Request field offsets (LSB positions)
  function automatic int req_src_lsb();
    return 0;
  endfunction

  function automatic int req_rd_bit(input int n_aw);
    return n_aw;
  endfunction

  function automatic int req_wr_bit(input int n_aw);
    return n_aw + 1;
  endfunction

  function automatic int req_addr_lsb(input int n_aw);
    return n_aw + 2;
  endfunction

  function automatic int req_data_lsb(input int n_aw, input int aw);
    return n_aw + 2 + aw;
  endfunction

  function automatic int req_width(input int w, input int aw, input int n_aw);
    return w + aw + 2 + n_aw;
  endfunction

  // Response field offsets (LSB positions)
  function automatic int rsp_ack_bit();
    return 0;
  endfunction

  function automatic int rsp_node_lsb();
    return 1;
  endfunction

  function automatic int rsp_data_lsb(input int n_aw);
    return n_aw + 1;
  endfunction

  function automatic int rsp_width(input int w, input int n_aw);
    return w + n_aw + 1;
  endfunction

  // Request word at the default widths, for producers built at defaults.
  typedef struct packed {
    logic [DEF_WIDTH-1:0]        data;
    logic [DEF_ADDR_WIDTH-1:0]   addr;
    logic                        wr;
    logic                        rd;
    logic [DEF_N_ADDR_WIDTH-1:0] src;
  } req_t;

  function automatic req_t build_req(
    input logic [DEF_WIDTH-1:0]        data,
    input logic [DEF_ADDR_WIDTH-1:0]   addr,
    input logic                        wr,
    input logic                        rd,
    input logic [DEF_N_ADDR_WIDTH-1:0] src
  );
    req_t r;
    r.data = data;
    r.addr = addr;
    r.wr   = wr;
    r.rd   = rd;
    r.src  = src;
    return r;
  endfunction

endpackage

// File: rtl/noc_ram_rsp_fifo.sv
// Response FIFO: power-of-two ring buffer with occupancy count.
// Latency: a push is visible at the head on the cycle after it is written.
// Backpressure: push ignored when full unless a pop happens the same cycle.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   push, push_data       write side
//   pop, pop_data         read side; pop_data is the current head
//   count, empty, full    occupancy status
module noc_ram_rsp_fifo #(
  parameter int  WIDTH = 8,
  parameter int  DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A simultaneous pop frees the slot, so push at full is still legal then.
  assign do_push = push & (~full | do_pop);

  assign pop_data = store[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      store[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/noc_ram.sv
// NoC-attached single-port RAM: read/write requests in, read/ack responses out.
// Latency: 2 edges from request accept to response valid (RAM read reg, FIFO).
// Backpressure: request ready drops once FIFO + in-flight stage fill RSP_DEPTH.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   i_packed_in  {data,addr,wr,rd,src}, with i_valid_in / i_ready_out
//   o_packed_out {data,NODE,is_ack} and o_dest_out (= request src),
//                with o_valid_out / o_ready_in
module noc_ram
  import noc_ram_pkg::*;
#(
  parameter int  WIDTH        = 32,
  parameter int  ADDR_WIDTH   = 10,
  parameter int  N            = 16,
  parameter int  NODE         = N - 1,
  parameter int  RSP_DEPTH    = 4,
  parameter int  WRITE_ACK    = 0,
  localparam int N_ADDR_WIDTH = $clog2(N),
  localparam int REQ_W        = req_width(WIDTH, ADDR_WIDTH, $clog2(N)),
  localparam int RSP_W        = rsp_width(WIDTH, $clog2(N))
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [REQ_W-1:0]        i_packed_in,
  input  logic                    i_valid_in,
  output logic                    i_ready_out,
  output logic [RSP_W-1:0]        o_packed_out,
  output logic [N_ADDR_WIDTH-1:0] o_dest_out,
  output logic                    o_valid_out,
  input  logic                    o_ready_in
);

  localparam int DEPTH     = 2 ** ADDR_WIDTH;
  localparam int CW        = $clog2(RSP_DEPTH) + 1;
  localparam int FIFO_W    = WIDTH + N_ADDR_WIDTH + 1;
  localparam int SRC_LSB   = req_src_lsb();
  localparam int RD_BIT    = req_rd_bit(N_ADDR_WIDTH);
  localparam int WR_BIT    = req_wr_bit(N_ADDR_WIDTH);
  localparam int ADDR_LSB  = req_addr_lsb(N_ADDR_WIDTH);
  localparam int DATA_LSB  = req_data_lsb(N_ADDR_WIDTH, ADDR_WIDTH);
  localparam logic ACK_EN  = (WRITE_ACK != 0);
  localparam logic [N_ADDR_WIDTH-1:0] NODE_ID = N_ADDR_WIDTH'(NODE);

  // Request fields
  logic [WIDTH-1:0]        req_data;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic                    req_wr;
  logic                    req_rd;
  logic [N_ADDR_WIDTH-1:0] req_src;

  assign req_data = i_packed_in[DATA_LSB +: WIDTH];
  assign req_addr = i_packed_in[ADDR_LSB +: ADDR_WIDTH];
  assign req_wr   = i_packed_in[WR_BIT];
  assign req_rd   = i_packed_in[RD_BIT];
  assign req_src  = i_packed_in[SRC_LSB +: N_ADDR_WIDTH];

  logic accept;
  logic want_rsp;
  logic ack_only;

  // A request presented while rst is high must leave no trace.
  assign accept   = i_valid_in & i_ready_out & ~rst;
  // wr+rd yields only the read response, never an extra ack.
  assign ack_only = ACK_EN & req_wr & ~req_rd;
  assign want_rsp = req_rd | ack_only;

  // Memory and stage-1 register
  logic [WIDTH-1:0]        mem [DEPTH];
  logic [WIDTH-1:0]        s1_rdata;
  logic [WIDTH-1:0]        s1_wdata;
  logic [N_ADDR_WIDTH-1:0] s1_src;
  logic                    s1_ack;
  logic                    s1_valid;

  // One port: the read returns the pre-write contents on a wr+rd request.
  // Read data is registered straight off the array so it maps onto the
  // RAM output register; the ack data path is kept separate.
  always_ff @(posedge clk) begin
    if (accept) begin
      if (req_wr) begin
        mem[req_addr] <= req_data;
      end
      s1_rdata <= mem[req_addr];
      s1_wdata <= req_data;
      s1_src   <= req_src;
      s1_ack   <= ack_only;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= accept & want_rsp;
    end
  end

  // Response FIFO
  logic [FIFO_W-1:0]       fifo_in;
  logic [FIFO_W-1:0]       fifo_head;
  logic [CW-1:0]           fifo_count;
  logic                    fifo_empty;
  logic                    fifo_full;
  logic [WIDTH-1:0]        s1_data;
  logic [WIDTH-1:0]        head_data;
  logic [N_ADDR_WIDTH-1:0] head_src;
  logic                    head_ack;

  assign s1_data = s1_ack ? s1_wdata : s1_rdata;
  assign fifo_in = {s1_data, s1_src, s1_ack};

  noc_ram_rsp_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (s1_valid),
    .push_data (fifo_in),
    .pop       (o_ready_in),
    .pop_data  (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign {head_data, head_src, head_ack} = fifo_head;

  // Reserve a FIFO slot for every accepted request that may respond,
  // counting the one still in stage 1. Same-cycle pops are deliberately
  // not credited so ready stays a function of registered state only.
  logic [CW:0] occupancy;

  assign occupancy   = (CW + 1)'(fifo_count) + (CW + 1)'(s1_valid);
  assign i_ready_out = ~fifo_full & (occupancy < (CW + 1)'(RSP_DEPTH));

  assign o_valid_out  = ~fifo_empty;
  assign o_packed_out = {head_data, NODE_ID, head_ack};
  assign o_dest_out   = head_src;

endmodule

// File: tb/tb_noc_ram.sv
// Self-checking bench for noc_ram: table of requests plus directed sequences.
// Two instances: default (WRITE_ACK=0, NODE=15) and an ack variant (NODE=6).
module tb_noc_ram;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [47:0] i_packed_in = '0;
  logic        i_valid_in = 1'b0;
  logic        i_ready_out;
  logic [36:0] o_packed_out;
  logic [3:0]  o_dest_out;
  logic        o_valid_out;
  logic        o_ready_in = 1'b1;

  logic [47:0] a_i_packed_in = '0;
  logic        a_i_valid_in = 1'b0;
  logic        a_i_ready_out;
  logic [36:0] a_o_packed_out;
  logic [3:0]  a_o_dest_out;
  logic        a_o_valid_out;
  logic        a_o_ready_in = 1'b1;

  always #5 clk = ~clk;

  noc_ram dut (
    .clk          (clk),
    .rst          (rst),
    .i_packed_in  (i_packed_in),
    .i_valid_in   (i_valid_in),
    .i_ready_out  (i_ready_out),
    .o_packed_out (o_packed_out),
    .o_dest_out   (o_dest_out),
    .o_valid_out  (o_valid_out),
    .o_ready_in   (o_ready_in)
  );

  noc_ram #(.NODE(6), .WRITE_ACK(1)) dut_ack (
    .clk          (clk),
    .rst          (rst),
    .i_packed_in  (a_i_packed_in),
    .i_valid_in   (a_i_valid_in),
    .i_ready_out  (a_i_ready_out),
    .o_packed_out (a_o_packed_out),
    .o_dest_out   (a_o_dest_out),
    .o_valid_out  (a_o_valid_out),
    .o_ready_in   (a_o_ready_in)
  );

  typedef struct {
    logic [31:0] data;
    logic [3:0]  dest;
    logic        ack;
  } exp_t;

  typedef struct {
    logic [31:0] data;
    logic [9:0]  addr;
    logic        wr;
    logic        rd;
    logic [3:0]  src;
    logic        exp_rsp;
    logic [31:0] exp_data;
  } vec_t;

  int          errors = 0;
  int          checks = 0;
  int          acc_cnt = 0;
  int          pops = 0;
  int          max_q = 0;
  int          cyc = 0;
  exp_t        q[$];
  logic [31:0] mdl [1024];
  vec_t        vecs [12];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard side: outstanding count must match ready, head must match queue.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (q.size() > max_q) max_q = q.size();
      chk("ready_vs_outstanding", i_ready_out, (q.size() < 4) ? 1'b1 : 1'b0);
      if (o_valid_out && o_ready_in) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got 0x%0h dest %0d, expected none", o_packed_out, o_dest_out);
        end else begin
          e = q.pop_front();
          chk("rsp_packed", o_packed_out, {e.data, 4'hF, e.ack});
          chk("rsp_dest", o_dest_out, e.dest);
          pops++;
        end
      end
    end
  end

  // Caller is at posedge+1. Returns at posedge+1 after acceptance.
  task automatic send_raw(input logic [47:0] pk, input logic do_push, input exp_t e);
    int t = 0;
    i_packed_in = pk;
    i_valid_in  = 1'b1;
    while (!i_ready_out && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 200) begin
      chk("accept_timeout", 1'b0, 1'b1);
      i_valid_in = 1'b0;
    end else begin
      @(posedge clk);
      if (do_push) q.push_back(e);
      acc_cnt++;
      #1;
      i_valid_in = 1'b0;
    end
  endtask

  task automatic tb_write(input logic [9:0] addr, input logic [31:0] data);
    exp_t e;
    e = '{data: 32'h0, dest: 4'h0, ack: 1'b0};
    mdl[addr] = data;
    send_raw({data, addr, 1'b1, 1'b0, 4'h0}, 1'b0, e);
  endtask

  task automatic tb_read(input logic [9:0] addr, input logic [3:0] src);
    exp_t e;
    e = '{data: mdl[addr], dest: src, ack: 1'b0};
    send_raw({32'h0, addr, 1'b0, 1'b1, src}, 1'b1, e);
  endtask

  task automatic drain();
    int t = 0;
    o_ready_in = 1'b1;
    while ((q.size() != 0 || o_valid_out) && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("drain_done", (t < 50) ? 1'b1 : 1'b0, 1'b1);
  endtask

  task automatic ack_req(input logic [47:0] pk, output int nrsp, output logic [36:0] pkt,
                         output logic [3:0] dst, output int lat);
    a_i_packed_in = pk;
    a_i_valid_in  = 1'b1;
    chk("ack_dut_ready", a_i_ready_out, 1'b1);
    @(posedge clk);
    #1;
    a_i_valid_in = 1'b0;
    nrsp = 0;
    lat  = -1;
    pkt  = '0;
    dst  = '0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (a_o_valid_out) begin
        if (nrsp == 0) begin
          pkt = a_o_packed_out;
          dst = a_o_dest_out;
          lat = c;
        end
        nrsp++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          n;
    int          l;
    int          c0;
    int          p0;
    logic [36:0] pk;
    logic [3:0]  ds;
    logic        seen;
    exp_t        e;

    vecs[0]  = '{32'h0000A5A5, 10'd5,    1'b1, 1'b0, 4'd1,  1'b0, 32'h0};
    vecs[1]  = '{32'h0,        10'd5,    1'b0, 1'b1, 4'd3,  1'b1, 32'h0000A5A5};
    vecs[2]  = '{32'h00000022, 10'd7,    1'b1, 1'b0, 4'd0,  1'b0, 32'h0};
    vecs[3]  = '{32'h00000011, 10'd7,    1'b1, 1'b1, 4'd1,  1'b1, 32'h00000022};
    vecs[4]  = '{32'h0,        10'd7,    1'b0, 1'b1, 4'd4,  1'b1, 32'h00000011};
    vecs[5]  = '{32'hDEADBEEF, 10'd0,    1'b1, 1'b0, 4'd2,  1'b0, 32'h0};
    vecs[6]  = '{32'h12345678, 10'd1023, 1'b1, 1'b0, 4'd8,  1'b0, 32'h0};
    vecs[7]  = '{32'h0,        10'd1023, 1'b0, 1'b1, 4'd15, 1'b1, 32'h12345678};
    vecs[8]  = '{32'h0,        10'd0,    1'b0, 1'b1, 4'd0,  1'b1, 32'hDEADBEEF};
    vecs[9]  = '{32'hFFFFFFFF, 10'd5,    1'b0, 1'b0, 4'd2,  1'b0, 32'h0};
    vecs[10] = '{32'h0,        10'd5,    1'b0, 1'b1, 4'd9,  1'b1, 32'h0000A5A5};
    vecs[11] = '{32'h00000055, 10'd30,   1'b1, 1'b0, 4'd0,  1'b0, 32'h0};

    // Reset
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_o_valid", o_valid_out, 1'b0);
    chk("reset_i_ready", i_ready_out, 1'b1);
    chk("reset_ack_o_valid", a_o_valid_out, 1'b0);
    @(posedge clk);
    #1;

    // Table-driven requests, back to back
    foreach (vecs[i]) begin
      e = '{data: vecs[i].exp_data, dest: vecs[i].src, ack: 1'b0};
      send_raw({vecs[i].data, vecs[i].addr, vecs[i].wr, vecs[i].rd, vecs[i].src},
               vecs[i].exp_rsp, e);
      if (vecs[i].wr) mdl[vecs[i].addr] = vecs[i].data;
    end
    drain();

    // Two-edge read latency
    i_packed_in = {32'h0, 10'd5, 1'b0, 1'b1, 4'd3};
    i_valid_in  = 1'b1;
    @(posedge clk);
    q.push_back('{data: 32'h0000A5A5, dest: 4'd3, ack: 1'b0});
    #1;
    i_valid_in = 1'b0;
    @(negedge clk);
    chk("latency_edge1_valid", o_valid_out, 1'b0);
    @(negedge clk);
    chk("latency_edge2_valid", o_valid_out, 1'b1);
    @(posedge clk);
    #1;
    drain();

    // Sustained throughput with o_ready_in high
    for (int k = 0; k < 16; k++) tb_write(10'(100 + k), 32'hC000_0000 + k);
    for (int k = 0; k < 6; k++) tb_write(10'(20 + k), 32'hB000_0000 + k);
    c0 = cyc;
    for (int k = 0; k < 8; k++) tb_read(10'(100 + k), 4'(k));
    chk("throughput_cycles", cyc - c0, 8);
    drain();

    // Backpressure: 6 reads into a stalled output, only 4 fit
    o_ready_in = 1'b0;
    acc_cnt = 0;
    fork
      begin
        for (int k = 0; k < 6; k++) tb_read(10'(20 + k), 4'(10 + k));
      end
    join_none
    repeat (10) @(posedge clk);
    #1;
    chk("stall_accepted", acc_cnt, 4);
    chk("stall_ready_low", i_ready_out, 1'b0);
    chk("stall_o_valid", o_valid_out, 1'b1);
    o_ready_in = 1'b1;
    wait fork;
    drain();
    chk("stall_all_accepted", acc_cnt, 6);

    // 16 back-to-back reads with o_ready_in toggling every cycle
    max_q = 0;
    p0 = pops;
    fork
      begin
        for (int c = 0; c < 40; c++) begin
          @(posedge clk);
          #1;
          o_ready_in = ~o_ready_in;
        end
      end
    join_none
    for (int k = 0; k < 16; k++) tb_read(10'(115 - k), 4'(k));
    wait fork;
    drain();
    chk("toggle_pops", pops - p0, 16);
    chk("toggle_max_outstanding_le4", (max_q <= 4) ? 1'b1 : 1'b0, 1'b1);

    // Write acknowledge on the ack instance, none on the default instance
    ack_req({32'h33, 10'd9, 1'b1, 1'b0, 4'd2}, n, pk, ds, l);
    chk("ack_count", n, 1);
    chk("ack_packed", pk, {32'h33, 4'd6, 1'b1});
    chk("ack_dest", ds, 4'd2);
    chk("ack_latency", l, 2);
    ack_req({32'h44, 10'd9, 1'b1, 1'b1, 4'd5}, n, pk, ds, l);
    chk("ack_rdwr_count", n, 1);
    chk("ack_rdwr_packed", pk, {32'h33, 4'd6, 1'b0});
    chk("ack_rdwr_dest", ds, 4'd5);

    tb_write(10'd9, 32'h33);
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (o_valid_out) seen = 1'b1;
    end
    chk("noack_no_rsp", seen, 1'b0);
    @(posedge clk);
    #1;

    // Reset with three queued responses; write during reset must be ignored
    o_ready_in = 1'b0;
    tb_read(10'd100, 4'd1);
    tb_read(10'd101, 4'd2);
    tb_read(10'd102, 4'd3);
    repeat (2) @(posedge clk);
    #1;
    chk("pre_reset_queued", o_valid_out, 1'b1);
    rst         = 1'b1;
    i_packed_in = {32'h99, 10'd30, 1'b1, 1'b0, 4'd0};
    i_valid_in  = 1'b1;
    q.delete();
    @(posedge clk);
    #1;
    rst        = 1'b0;
    i_valid_in = 1'b0;
    o_ready_in = 1'b1;
    @(negedge clk);
    chk("post_reset_o_valid", o_valid_out, 1'b0);
    chk("post_reset_i_ready", i_ready_out, 1'b1);
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (o_valid_out) seen = 1'b1;
    end
    chk("post_reset_no_stale", seen, 1'b0);
    @(posedge clk);
    #1;
    tb_read(10'd30, 4'd7);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/noc_ram.md
NOC_RAM -- requirements
Module: noc_ram

Interface
REQ-001 Parameter WIDTH, 32, data word width in bits.
REQ-002 Parameter ADDR_WIDTH, 10, word address width; DEPTH = 2**ADDR_WIDTH.
REQ-003 Parameter N, 16, NoC node count; N_ADDR_WIDTH = $clog2(N).
REQ-004 Parameter NODE, N-1, own node id, inserted in every response.
REQ-005 Parameter RSP_DEPTH, 4, response FIFO entries, power of two, >=2.
REQ-006 Parameter WRITE_ACK, 0, 1 = every accepted write also generates a response.
REQ-007 clk  in  1  clock.
REQ-008 rst  in  1  reset, synchronous, active-high.
REQ-009 i_packed_in  in  WIDTH+ADDR_WIDTH+2+N_ADDR_WIDTH  request {data, addr, wr, rd, src}, MSB first.
REQ-010 i_valid_in  in  1  request valid.
REQ-011 i_ready_out  out  1  request accepted this cycle when high with i_valid_in.
REQ-012 o_packed_out  out  WIDTH+N_ADDR_WIDTH+1  response {data, NODE, is_ack}.
REQ-013 o_dest_out  out  N_ADDR_WIDTH  response destination = request src.
REQ-014 o_valid_out  out  1  response valid.
REQ-015 o_ready_in  in  1  downstream accepts response when high with o_valid_out.

Function
REQ-016 Request accepted iff i_valid_in & i_ready_out on rising clk.
REQ-017 Accepted wr=1 writes data to memory[addr] at that edge.
REQ-018 Accepted rd=1 reads memory[addr] at that edge (old data if wr=1 same request: read-before-write).
REQ-019 Read data, src, is_ack=0 enter response FIFO exactly one cycle after acceptance (stage-1 register).
REQ-020 WRITE_ACK=1: accepted wr=1 with rd=0 enqueues {written data, src, is_ack=1} via same stage; wr=1 & rd=1 enqueues one read response only.
REQ-021 Accepted request with rd=0 and (wr=0 or WRITE_ACK=0) produces no response.
REQ-022 i_ready_out = (fifo_count + stage1_valid) < RSP_DEPTH, combinational from registered state only; no dependence on i_valid_in or o_ready_in.
REQ-023 FIFO never overflows; responses never dropped; order preserved.
REQ-024 o_valid_out = FIFO not empty; o_packed_out/o_dest_out = FIFO head, stable while o_valid_out & ~o_ready_in.
REQ-025 Pop on o_valid_out & o_ready_in; push and pop in same cycle leave count unchanged, legal at full and at empty-after-push.
REQ-026 Minimum read latency: acceptance edge to o_valid_out high = 2 edges (stage-1 then FIFO write); sustained throughput 1 response/cycle with o_ready_in held high.
REQ-027 FIFO pointers wrap modulo RSP_DEPTH; count width $clog2(RSP_DEPTH)+1.

Reset
REQ-028 rst clears stage1_valid, FIFO pointers and count; o_valid_out=0, i_ready_out=1 on first cycle after reset.
REQ-029 Memory contents not reset; request accepted in reset cycle is ignored (no write, no response).
REQ-030 rst mid-operation discards in-flight stage-1 and all queued responses.

Structure
REQ-031 Package noc_ram_pkg holds request/response field offset constants and a packed-request struct builder function.
REQ-032 Response FIFO is sub-module noc_ram_rsp_fifo (WIDTH, DEPTH params, push/pop/count/empty/full).
REQ-033 Memory inferred as single-port synchronous RAM, one access per cycle.

Verification
REQ-034 Write addr 5 data 0xA5A5, then read addr 5 src 3 -> response data 0xA5A5, dest 3, is_ack=0, o_valid_out 2 edges after read accept.
REQ-035 o_ready_in=0, issue 6 reads (RSP_DEPTH=4) -> exactly 4 accepted, i_ready_out low after 4th; raise o_ready_in -> 4 responses in order, remaining reads then accepted.
REQ-036 Same request wr=1 rd=1 addr 7 data 0x11 over old 0x22 -> response 0x22; next read addr 7 -> 0x11.
REQ-037 WRITE_ACK=1, write addr 9 data 0x33 src 2 -> response data 0x33, dest 2, is_ack=1; WRITE_ACK=0 same -> no response.
REQ-038 Back-to-back 16 reads, o_ready_in toggling 1/0 every cycle -> no loss, no duplication, order kept, count never exceeds 4.
REQ-039 Assert rst with 3 queued responses -> o_valid_out=0 next cycle, no stale response after release.
